// File: rtl/duck_hunt_pkg.sv
// duck_hunt_pkg: round states and default game constants shared by the sequencer slice
package duck_hunt_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_SPAWN, ACTIVE, RESOLVE, NEXT, GAME_OVER} round_state_t;
  localparam int TARGETS = 10;
  localparam int AMMO = 3;
  localparam int PASS_HITS = 6;
endpackage

// File: rtl/ctl_round_sequencer_if.sv
// ctl_round_sequencer_if: game-flow pulses in, trigger lock and score state out
interface ctl_round_sequencer_if #(parameter int TARGETS = duck_hunt_pkg::TARGETS);
  logic new_frame, start, shot_fired, hit, miss, target_escaped;
  logic lock, target_spawn, target_kill, game_over, passed;
  logic [3:0] target_idx, hit_count;
  logic [1:0] ammo;
  logic [TARGETS-1:0] hit_mask;
  modport master(
    output new_frame, start, shot_fired, hit, miss, target_escaped,
    input lock, target_spawn, target_kill, target_idx, ammo, hit_count, hit_mask, game_over, passed
  );
  modport slave(
    input new_frame, start, shot_fired, hit, miss, target_escaped,
    output lock, target_spawn, target_kill, target_idx, ammo, hit_count, hit_mask, game_over, passed
  );
endinterface

// File: rtl/ctl_round_sequencer_frame_timer.sv
// frame_timer: counts new_frame pulses, done on the pulse that reaches the terminal count
module frame_timer #(parameter int W = 5) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] terminal,
  output logic         done
);
  logic [W-1:0] count;
  assign done = en && !clear && count == terminal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + W'(1);
  end
endmodule

// File: rtl/ctl_round_sequencer.sv
// ctl_round_sequencer: sequences one game of targets x shots, drives trigger lock and score
module ctl_round_sequencer #(
  parameter int TARGETS        = duck_hunt_pkg::TARGETS,
  parameter int AMMO           = duck_hunt_pkg::AMMO,
  parameter int SPAWN_FRAMES   = 30,
  parameter int RESOLVE_FRAMES = 12,
  parameter int PASS_HITS      = duck_hunt_pkg::PASS_HITS
) (
  input logic clk,
  input logic rst,
  ctl_round_sequencer_if.slave bus
);
  import duck_hunt_pkg::*;
  localparam int TW = $clog2((SPAWN_FRAMES > RESOLVE_FRAMES ? SPAWN_FRAMES : RESOLVE_FRAMES) + 1);
  round_state_t state;
  logic start_q, esc_seen, timer_done, timer_clear;
  logic [TW-1:0] terminal;
  // one timer serves both the spawn delay and the shot-resolve timeout
  assign timer_clear = !(state == WAIT_SPAWN || state == RESOLVE);
  assign terminal = state == WAIT_SPAWN ? TW'(SPAWN_FRAMES - 1) : TW'(RESOLVE_FRAMES - 1);
  frame_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .clear(timer_clear), .en(bus.new_frame), .terminal(terminal), .done(timer_done)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      start_q <= 1'b0;
      esc_seen <= 1'b0;
      bus.lock <= 1'b1;
      bus.target_spawn <= 1'b0;
      bus.target_kill <= 1'b0;
      bus.target_idx <= '0;
      bus.ammo <= '0;
      bus.hit_count <= '0;
      bus.hit_mask <= '0;
      bus.game_over <= 1'b0;
      bus.passed <= 1'b0;
    end else begin
      start_q <= bus.start;
      bus.lock <= 1'b1;
      bus.target_spawn <= 1'b0;
      bus.target_kill <= 1'b0;
      case (state)
        IDLE, GAME_OVER: if (state == IDLE ? bus.start : bus.start && !start_q) begin
          state <= WAIT_SPAWN;
          bus.target_idx <= '0;
          bus.ammo <= '0;
          bus.hit_count <= '0;
          bus.hit_mask <= '0;
          bus.game_over <= 1'b0;
          bus.passed <= 1'b0;
        end
        WAIT_SPAWN: if (timer_done) begin
          bus.target_spawn <= 1'b1;
          bus.ammo <= 2'(AMMO);
          bus.lock <= 1'b0;
          state <= ACTIVE;
        end
        ACTIVE: if (bus.shot_fired) begin
          bus.ammo <= bus.ammo - 2'd1;
          esc_seen <= 1'b0;
          state <= RESOLVE;
        end else if (bus.target_escaped) state <= NEXT;
        else bus.lock <= 1'b0;
        RESOLVE: begin
          if (bus.target_escaped) esc_seen <= 1'b1;
          if (bus.hit) begin
            bus.target_kill <= 1'b1;
            if (bus.hit_count != 4'd15) bus.hit_count <= bus.hit_count + 4'd1;
            bus.hit_mask <= bus.hit_mask | (TARGETS'(1) << bus.target_idx);
            state <= NEXT;
          end else if (bus.miss || timer_done) begin
            // an escape seen while the shot was in flight ends the target even with ammo left
            if (bus.ammo != 2'd0 && !esc_seen && !bus.target_escaped) begin
              bus.lock <= 1'b0;
              state <= ACTIVE;
            end else state <= NEXT;
          end
        end
        NEXT: if (bus.target_idx == 4'(TARGETS - 1)) begin
          bus.game_over <= 1'b1;
          bus.passed <= bus.hit_count >= 4'(PASS_HITS);
          state <= GAME_OVER;
        end else begin
          bus.target_idx <= bus.target_idx + 4'd1;
          state <= WAIT_SPAWN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ctl_round_sequencer.sv
// tb_ctl_round_sequencer: directed game scenarios checked every cycle against a game-rule model
module tb_ctl_round_sequencer;
  localparam int TARGETS = 10, AMMO = 3, SPAWN = 30, RES = 12, PASS = 6;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  ctl_round_sequencer_if #(.TARGETS(TARGETS)) bus();
  ctl_round_sequencer #(
    .TARGETS(TARGETS), .AMMO(AMMO), .SPAWN_FRAMES(SPAWN), .RESOLVE_FRAMES(RES), .PASS_HITS(PASS)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  int errors = 0, checks = 0;
  typedef enum int {P_IDLE, P_WAIT, P_AIM, P_FLY, P_GAP, P_OVER} phase_t;
  phase_t ph;
  int frames, idx, shots, hits;
  logic [TARGETS-1:0] mask;
  bit over, pass, spawn, kill, esc, prev_start;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    ph = P_IDLE; frames = 0; idx = 0; shots = 0; hits = 0; mask = '0;
    over = 0; pass = 0; spawn = 0; kill = 0; esc = 0; prev_start = 0;
  endtask
  task automatic new_game();
    ph = P_WAIT; frames = 0; idx = 0; shots = 0; hits = 0; mask = '0; over = 0; pass = 0;
  endtask
  task automatic model_step();
    bit rise;
    rise = bus.start && !prev_start;
    prev_start = bus.start;
    spawn = 0;
    kill = 0;
    if ((ph == P_IDLE && bus.start) || (ph == P_OVER && rise)) new_game();
    else if (ph == P_WAIT) begin
      frames += int'(bus.new_frame);
      if (frames == SPAWN) begin spawn = 1; shots = AMMO; ph = P_AIM; end
    end else if (ph == P_AIM) begin
      if (bus.shot_fired) begin shots--; frames = 0; esc = 0; ph = P_FLY; end
      else if (bus.target_escaped) ph = P_GAP;
    end else if (ph == P_FLY) begin
      esc |= bus.target_escaped;
      frames += int'(bus.new_frame);
      if (bus.hit) begin
        kill = 1; hits = hits < 15 ? hits + 1 : 15; mask[idx] = 1'b1; ph = P_GAP;
      end else if (bus.miss || frames == RES) ph = (shots > 0 && !esc) ? P_AIM : P_GAP;
    end else if (ph == P_GAP) begin
      if (idx == TARGETS - 1) begin over = 1; pass = hits >= PASS; ph = P_OVER; end
      else begin idx++; frames = 0; ph = P_WAIT; end
    end
  endtask
  task automatic compare_all();
    chk("lock", int'(bus.lock), int'(ph != P_AIM));
    chk("target_spawn", int'(bus.target_spawn), int'(spawn));
    chk("target_kill", int'(bus.target_kill), int'(kill));
    chk("target_idx", int'(bus.target_idx), idx);
    chk("ammo", int'(bus.ammo), shots);
    chk("hit_count", int'(bus.hit_count), hits);
    chk("hit_mask", int'(bus.hit_mask), int'(mask));
    chk("game_over", int'(bus.game_over), int'(over));
    chk("passed", int'(bus.passed), int'(pass));
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    bus.new_frame = 0; bus.shot_fired = 0; bus.hit = 0; bus.miss = 0; bus.target_escaped = 0;
  endtask
  task automatic frames_n(int n);
    repeat (n) begin
      tick();
      bus.new_frame = 1;
      tick();
    end
  endtask
  task automatic shot();
    bus.shot_fired = 1;
    tick();
  endtask
  initial begin
    bus.start = 0; bus.new_frame = 0; bus.shot_fired = 0; bus.hit = 0; bus.miss = 0; bus.target_escaped = 0;
    model_reset();
    #12;
    compare_all();
    chk("reset_lock", int'(bus.lock), 1);
    chk("reset_ammo", int'(bus.ammo), 0);
    rst = 0;
    bus.start = 1; tick(); bus.start = 0;
    frames_n(SPAWN);
    chk("spawn_after_30", int'(bus.target_spawn), 1);
    chk("spawn_ammo", int'(bus.ammo), 3);
    chk("spawn_lock", int'(bus.lock), 0);
    chk("spawn_idx", int'(bus.target_idx), 0);
    shot(); repeat (4) tick();
    chk("resolve_lock", int'(bus.lock), 1);
    chk("resolve_ammo", int'(bus.ammo), 2);
    bus.hit = 1; tick();
    chk("kill_pulse", int'(bus.target_kill), 1);
    chk("hit_count_1", int'(bus.hit_count), 1);
    chk("hit_mask_0", int'(bus.hit_mask), 1);
    tick();
    chk("idx_after_hit", int'(bus.target_idx), 1);
    frames_n(SPAWN);
    repeat (3) begin shot(); tick(); bus.miss = 1; tick(); end
    chk("ammo_exhausted", int'(bus.ammo), 0);
    tick();
    chk("idx_after_misses", int'(bus.target_idx), 2);
    chk("mask_after_misses", int'(bus.hit_mask), 1);
    frames_n(SPAWN);
    bus.shot_fired = 1; bus.target_escaped = 1; tick();
    chk("shot_beats_escape", int'(bus.lock), 1);
    shot();
    chk("extra_shot_ignored", int'(bus.ammo), 2);
    frames_n(RES);
    chk("timeout_lock", int'(bus.lock), 0);
    chk("timeout_ammo", int'(bus.ammo), 2);
    shot(); bus.hit = 1; bus.miss = 1; tick();
    chk("hit_beats_miss", int'(bus.hit_count), 2);
    tick();
    frames_n(SPAWN);
    shot(); bus.target_escaped = 1; tick(); bus.miss = 1; tick();
    chk("escape_latched_ammo", int'(bus.ammo), 2);
    tick();
    chk("escape_latched_idx", int'(bus.target_idx), 4);
    frames_n(SPAWN);
    bus.target_escaped = 1; tick(); tick();
    chk("escape_active_idx", int'(bus.target_idx), 5);
    bus.start = 1; tick(); bus.start = 0;
    repeat (5) begin frames_n(SPAWN); shot(); bus.hit = 1; tick(); tick(); end
    chk("final_game_over", int'(bus.game_over), 1);
    chk("final_passed", int'(bus.passed), 1);
    chk("final_hits", int'(bus.hit_count), 7);
    chk("final_mask", int'(bus.hit_mask), 997);
    chk("final_lock", int'(bus.lock), 1);
    repeat (3) tick();
    bus.start = 1; tick();
    chk("restart_hits", int'(bus.hit_count), 0);
    chk("restart_over", int'(bus.game_over), 0);
    frames_n(SPAWN);
    chk("restart_spawn", int'(bus.target_spawn), 1);
    shot(); tick();
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_lock", int'(bus.lock), 1);
    chk("async_rst_ammo", int'(bus.ammo), 0);
    chk("async_rst_idx", int'(bus.target_idx), 0);
    #2 rst = 0;
    bus.start = 0;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
